rect_fill_ctrl: RTL and testbench
=================================

Name: rect_fill_ctrl

Overview:
- Sequences a pair of x/y coordinate sweeps to drive the VGA adapter's pixel-write port, one pixel per clock.
- Fills a programmable rectangle with a single colour, optionally clearing the full screen to black first.
- Sits between the top-level task controller (start/done handshake) and the VGA adapter (x, y, colour, plot).

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- XW, 8, x coordinate width; must satisfy 2^XW >= H_RES.
- YW, 7, y coordinate width; must satisfy 2^YW >= V_RES.
- CW, 3, colour width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request a fill; sampled only in IDLE.
- clear_first  in  1  sampled with start; 1 = clear the whole screen to colour 0 before the fill.
- pause  in  1  freeze the sweep (deassert plot, hold position) while high.
- x0  in  XW  rectangle left edge, inclusive.
- y0  in  YW  rectangle top edge, inclusive.
- x1  in  XW  rectangle right edge, inclusive.
- y1  in  YW  rectangle bottom edge, inclusive.
- colour_in  in  CW  fill colour.
- vga_x  out  XW  pixel x to adapter.
- vga_y  out  YW  pixel y to adapter.
- vga_colour  out  CW  pixel colour to adapter.
- vga_plot  out  1  pixel write strobe.
- busy  out  1  high in CLEAR or FILL.
- done  out  1  operation complete.
- err  out  1  last request rejected as invalid.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; vga_x, vga_y, vga_colour, vga_plot, busy, done and err all 0; latched region registers 0. Reset mid-sweep aborts the sweep immediately with no further plots.
- All outputs are registered.
- IDLE:
  - On an edge with start = 1, latch x0, y0, x1, y1, colour_in and clear_first.
  - Invalid request (x0 > x1, y0 > y1, x1 >= H_RES or y1 >= V_RES): go to DONE with err = 1; no plot is ever asserted.
  - Valid request with clear_first = 1: go to CLEAR, loading vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 1, busy = 1.
  - Valid request with clear_first = 0: go to FILL, loading vga_x = x0, vga_y = y0, vga_colour = latched colour, vga_plot = 1, busy = 1.
  - err is cleared on acceptance of any start.
- Sweep order in CLEAR and FILL: row-major, x inner and y outer, one pixel per non-paused cycle.
  - x wraps from its row end (H_RES-1 in CLEAR, x1 in FILL) back to its row start (0 or x0) and y increments.
- CLEAR:
  - After presenting (H_RES-1, V_RES-1), load (x0, y0) with the fill colour and enter FILL.
  - There is no gap cycle: plot stays high across the transition.
- FILL: after presenting (x1, y1), go to DONE; vga_plot = 0, busy = 0, done = 1 on that edge.
- pause:
  - While pause = 1 in CLEAR or FILL, vga_plot = 0 and position, colour and state are held.
  - Vga_plot reasserts on the edge after pause falls, at the same pixel; no pixel is skipped or duplicated.
  - pause is ignored in IDLE and DONE.
- Plot count per request: (x1-x0+1)*(y1-y0+1), plus H_RES*V_RES if clear_first.
- Latency: with start sampled at edge N, the first plot is visible after edge N; done rises at the edge following the last plot cycle.
- DONE:
  - done held at 1 (err as set) until start = 0 is sampled, then go to IDLE with done = 0.
  - err persists into IDLE until the next start is accepted.
  - A start held high continuously does not retrigger.
- Inputs other than pause are ignored outside IDLE; changes mid-sweep have no effect.

Test Plan:
- Basic fill: reset, x0=2, y0=3, x1=4, y1=4, colour_in=5, start pulse -> exactly 6 consecutive plot cycles (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), colour 5; done=1 on the next cycle; busy high only during the 6 plots.
- Single pixel with start held high: x0=x1=159, y0=y1=119, colour_in=7 -> one plot at (159,119); done stays 1 while start stays high; no second plot; IDLE after start drops.
- Clear then fill: clear_first=1, region (0,0)-(1,0), colour_in=2 -> 19200 plots of colour 0 in row-major order ending at (159,119), immediately followed by (0,0) and (1,0) in colour 2; total 19202 contiguous plot cycles, then done.
- Invalid requests: x0=5, x1=4 -> zero plots, done=1 and err=1 one cycle after start. Then x1=160 -> same result. Then a valid request -> err cleared.
- Pause: region (0,0)-(3,0), pause high for 3 cycles after the second plot -> plot low for 3 cycles, resumes at (2,0); 4 plots total, no duplicates.
- Reset mid-operation: assert reset during FILL at pixel (3,3) of region (0,0)-(9,9) -> all outputs 0 asynchronously; after release, no plot until a new start; a new request completes normally.

Source files
------------

// File: rtl/rect_fill_ctrl.sv
// rect_fill_ctrl: sweeps a rectangle (optionally after a full-screen clear) into the VGA adapter pixel port
//   clk, reset (async active-low)
//   start/clear_first/x0/y0/x1/y1/colour_in : request, sampled in IDLE
//   pause                                   : freeze the sweep
//   vga_x/vga_y/vga_colour/vga_plot         : adapter pixel write
//   busy/done/err                           : status to task controller
module rect_fill_ctrl #(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          clear_first,
    input  logic          pause,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;
    state_t state;
    logic [XW-1:0] rx0, rx1, row_beg, row_end;
    logic [YW-1:0] ry0, ry1, col_end;
    logic [CW-1:0] rcol;
    logic bad, in_clr, at_eol, last;
    // Extra bit on the bound compare so H_RES == 2^XW still works.
    always_comb begin
        bad     = (x0 > x1) || (y0 > y1) || ({1'b0, x1} >= (XW+1)'(H_RES)) || ({1'b0, y1} >= (YW+1)'(V_RES));
        in_clr  = state == CLEAR;
        row_beg = in_clr ? '0 : rx0;
        row_end = in_clr ? XW'(H_RES - 1) : rx1;
        col_end = in_clr ? YW'(V_RES - 1) : ry1;
        at_eol  = vga_x == row_end;
        last    = at_eol && (vga_y == col_end);
    end
    // A cycle with vga_plot high consumes the presented pixel, so the position
    // advances on that edge even if pause is high; the next pixel then waits with
    // plot low until pause is sampled low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rx0        <= '0;
            rx1        <= '0;
            ry0        <= '0;
            ry1        <= '0;
            rcol       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rx0  <= x0;
                    rx1  <= x1;
                    ry0  <= y0;
                    ry1  <= y1;
                    rcol <= colour_in;
                    err  <= bad;
                    done <= bad;
                    if (bad) state <= DONE;
                    else begin
                        state      <= clear_first ? CLEAR : FILL;
                        vga_x      <= clear_first ? '0 : x0;
                        vga_y      <= clear_first ? '0 : y0;
                        vga_colour <= clear_first ? '0 : colour_in;
                        vga_plot   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                CLEAR, FILL: begin
                    if (!vga_plot) vga_plot <= !pause;
                    else if (last && in_clr) begin
                        state      <= FILL;
                        vga_x      <= rx0;
                        vga_y      <= ry0;
                        vga_colour <= rcol;
                        vga_plot   <= !pause;
                    end else if (last) begin
                        state    <= DONE;
                        vga_plot <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        vga_x    <= at_eol ? row_beg : vga_x + XW'(1);
                        vga_y    <= at_eol ? vga_y + YW'(1) : vga_y;
                        vga_plot <= !pause;
                    end
                end
                DONE: if (!start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_ctrl.sv
// tb_rect_fill_ctrl: directed self-checking bench for rect_fill_ctrl
module tb_rect_fill_ctrl;
    logic       clk = 0, reset = 1, start = 0, clear_first = 0, pause = 0;
    logic [7:0] x0 = 0, x1 = 0;
    logic [6:0] y0 = 0, y1 = 0;
    logic [2:0] colour_in = 0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done, err;
    int n_cmp = 0, n_fail = 0;
    int qx[$], qy[$], qc[$];
    int gaps, done_seen;

    rect_fill_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .clear_first(clear_first), .pause(pause),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int ax0, input int ay0, input int ax1, input int ay1, input int col, input int clr);
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        colour_in = 3'(col); clear_first = clr[0];
    endtask

    // records plotted pixels from the current cycle onward until done rises
    task automatic collect(input int maxc);
        qx.delete(); qy.delete(); qc.delete();
        gaps = 0; done_seen = 0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            if (vga_plot) begin
                qx.push_back(int'(vga_x)); qy.push_back(int'(vga_y)); qc.push_back(int'(vga_colour));
            end
            if (busy && !vga_plot) gaps++;
            step();
        end
        check("done_within_budget", done_seen, 1);
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_x"}, int'(vga_x), 0);
        check({tag, "_y"}, int'(vga_y), 0);
        check({tag, "_col"}, int'(vga_colour), 0);
        check({tag, "_plot"}, int'(vga_plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int bad, k, ex[6], ey[6];
        // reset
        #2 reset = 0;
        step(); step();
        check_idle_outs("reset");
        reset = 1;
        step();
        check("idle_plot", int'(vga_plot), 0);

        // basic fill (2,3)-(4,4) colour 5
        req(2, 3, 4, 4, 5, 0);
        start = 1;
        step();
        start = 0;
        check("basic_first_plot", int'(vga_plot), 1);
        check("basic_first_busy", int'(busy), 1);
        collect(20);
        ex = '{2, 3, 4, 2, 3, 4};
        ey = '{3, 3, 3, 4, 4, 4};
        check("basic_count", qx.size(), 6);
        check("basic_gaps", gaps, 0);
        bad = 0;
        for (int i = 0; i < 6 && i < qx.size(); i++)
            if (qx[i] != ex[i] || qy[i] != ey[i] || qc[i] != 5) bad++;
        check("basic_order", bad, 0);
        check("basic_done_busy", int'(busy), 0);
        check("basic_done_plot", int'(vga_plot), 0);
        check("basic_err", int'(err), 0);
        step();
        check("basic_back_idle", int'(done), 0);

        // single pixel, start held high
        req(159, 119, 159, 119, 7, 0);
        start = 1;
        step();
        collect(10);
        check("single_count", qx.size(), 1);
        if (qx.size() > 0) begin
            check("single_x", qx[0], 159);
            check("single_y", qy[0], 119);
            check("single_col", qc[0], 7);
        end
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (vga_plot || !done) k++;
        end
        check("single_hold_done", k, 0);
        start = 0;
        step();
        check("single_idle_done", int'(done), 0);
        step();
        check("single_idle_plot", int'(vga_plot), 0);

        // clear then fill (0,0)-(1,0) colour 2
        req(0, 0, 1, 0, 2, 1);
        start = 1;
        step();
        start = 0;
        clear_first = 0;
        collect(20000);
        check("clear_count", qx.size(), 19202);
        check("clear_gaps", gaps, 0);
        bad = 0;
        for (int i = 0; i < 19200 && i < qx.size(); i++)
            if (qx[i] != i % 160 || qy[i] != i / 160 || qc[i] != 0) bad++;
        check("clear_order", bad, 0);
        if (qx.size() == 19202) begin
            check("clear_fill0", qx[19200] * 1000 + qy[19200] * 10 + qc[19200], 2);
            check("clear_fill1", qx[19201] * 1000 + qy[19201] * 10 + qc[19201], 1002);
        end
        start = 0;
        step();

        // invalid: x0 > x1
        req(5, 0, 4, 0, 1, 0);
        start = 1;
        step();
        start = 0;
        check("inv1_done", int'(done), 1);
        check("inv1_err", int'(err), 1);
        check("inv1_plot", int'(vga_plot), 0);
        check("inv1_busy", int'(busy), 0);
        step();
        check("inv1_idle_done", int'(done), 0);
        check("inv1_err_persist", int'(err), 1);
        // invalid: x1 out of range
        req(0, 0, 160, 0, 1, 0);
        start = 1;
        step();
        start = 0;
        check("inv2_done", int'(done), 1);
        check("inv2_err", int'(err), 1);
        check("inv2_plot", int'(vga_plot), 0);
        step();
        // valid request clears err
        req(0, 0, 0, 0, 1, 0);
        start = 1;
        step();
        start = 0;
        check("valid_err_cleared", int'(err), 0);
        check("valid_plot", int'(vga_plot), 1);
        collect(10);
        check("valid_count", qx.size(), 1);
        step();

        // pause after second plot of (0,0)-(3,0)
        req(0, 0, 3, 0, 3, 0);
        start = 1;
        step();
        start = 0;
        check("pause_p0", int'(vga_plot) * 100 + int'(vga_x), 100);
        step();
        check("pause_p1", int'(vga_plot) * 100 + int'(vga_x), 101);
        pause = 1;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (vga_plot || !busy) k++;
        end
        check("pause_low3", k, 0);
        pause = 0;
        collect(10);
        check("pause_rest_count", qx.size(), 2);
        if (qx.size() == 2) begin
            check("pause_resume_x", qx[0], 2);
            check("pause_last_x", qx[1], 3);
        end
        step();

        // reset during fill of (0,0)-(9,9) at pixel (3,3)
        req(0, 0, 9, 9, 4, 0);
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 33; i++) step();
        check("rst_at_x", int'(vga_x), 3);
        check("rst_at_y", int'(vga_y), 3);
        check("rst_at_plot", int'(vga_plot), 1);
        #2 reset = 0;
        #1;
        check_idle_outs("rst_async");
        step();
        reset = 1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vga_plot || busy) k++;
        end
        check("rst_no_plot", k, 0);
        req(5, 5, 6, 5, 6, 0);
        start = 1;
        step();
        start = 0;
        collect(10);
        check("rst_new_count", qx.size(), 2);
        if (qx.size() == 2) begin
            check("rst_new_p0", qx[0] * 1000 + qy[0] * 10 + qc[0], 5056);
            check("rst_new_p1", qx[1] * 1000 + qy[1] * 10 + qc[1], 6056);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
